// File: rtl/dcache_refill_unit.sv
// L1 data-cache miss refill: fetches a 16-beat burst from memory, assembles the line,
// and returns it to the controller with a single-cycle fill strobe. Keeps saturating miss counters.
module dcache_refill_unit #(
  parameter int BLOCK_BITS = 1024,
  parameter int BEAT_BITS  = 64,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic                  miss_is_write,
  input  logic [ADDR_W-1:0]     miss_addr,
  output logic                  miss_ready,
  output logic                  mem_req_valid,
  output logic [ADDR_W-1:0]     mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [BEAT_BITS-1:0]  mem_resp_data,
  output logic                  fill_valid,
  output logic [ADDR_W-1:0]     fill_addr,
  output logic [BLOCK_BITS-1:0] fill_data,
  output logic                  fill_is_write,
  output logic                  busy,
  output logic [31:0]           rd_miss_count,
  output logic [31:0]           wr_miss_count
);

  // state | meaning
  // IDLE  | waiting for a miss; only state that accepts a request
  // REQ   | burst request presented to memory, held until accepted
  // RECV  | collecting beats into the line buffer, gaps allowed
  // FILL  | one-cycle fill strobe back to the cache controller

  localparam int BEATS = BLOCK_BITS / BEAT_BITS;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_BITS / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2,
    S_FILL = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic                    is_write_q;
  logic [CNT_W-1:0]        beat_cnt;
  logic [BLOCK_BITS-1:0]   line_q;
  logic                    accept;
  logic                    beat_fire;
  logic                    last_beat;

  assign accept    = miss_valid && (state_q == S_IDLE);
  assign beat_fire = mem_resp_valid && (state_q == S_RECV);
  assign last_beat = beat_fire && (beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (miss_valid) state_d = S_REQ;
      S_REQ:   if (mem_req_ready) state_d = S_RECV;
      S_RECV:  if (last_beat) state_d = S_FILL;
      S_FILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    fill_valid    = 1'b0;
    busy          = 1'b1;
    case (state_q)
      S_IDLE: begin
        miss_ready = 1'b1;
        busy       = 1'b0;
      end
      S_REQ:   mem_req_valid = 1'b1;
      S_FILL:  fill_valid    = 1'b1;
      default: ;
    endcase
  end

  // Line, address and type stay registered so the fill view is stable until the next accept.
  assign mem_req_addr  = addr_q;
  assign fill_addr     = addr_q;
  assign fill_data     = line_q;
  assign fill_is_write = is_write_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      is_write_q    <= 1'b0;
      beat_cnt      <= '0;
      line_q        <= '0;
      rd_miss_count <= '0;
      wr_miss_count <= '0;
    end else begin
      if (accept) begin
        addr_q     <= miss_addr & ~OFF_MASK;
        is_write_q <= miss_is_write;
        beat_cnt   <= '0;
        if (miss_is_write) begin
          if (wr_miss_count != '1) wr_miss_count <= wr_miss_count + 32'd1;
        end else begin
          if (rd_miss_count != '1) rd_miss_count <= rd_miss_count + 32'd1;
        end
      end
      if (beat_fire) begin
        line_q[int'(beat_cnt) * BEAT_BITS +: BEAT_BITS] <= mem_resp_data;
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Randomized bench for dcache_refill_unit: a reactive memory drives bursts while a
// high-level model predicts fill latency, line contents and saturating miss counts.
module tb_dcache_refill_unit;

  logic          clk;
  logic          rst;
  logic          miss_valid;
  logic          miss_is_write;
  logic [31:0]   miss_addr;
  logic          miss_ready;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [63:0]   mem_resp_data;
  logic          fill_valid;
  logic [31:0]   fill_addr;
  logic [1023:0] fill_data;
  logic          fill_is_write;
  logic          busy;
  logic [31:0]   rd_miss_count;
  logic [31:0]   wr_miss_count;

  dcache_refill_unit dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_is_write(miss_is_write), .miss_addr(miss_addr),
    .miss_ready(miss_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_is_write(fill_is_write), .busy(busy),
    .rd_miss_count(rd_miss_count), .wr_miss_count(wr_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  longint rd_exp = 0;
  longint wr_exp = 0;

  logic [63:0]   beat_data [16];
  int            fill_cyc;
  int            n_fill;
  int            n_req;
  logic [31:0]   req_addr_seen;
  logic [31:0]   got_addr;
  logic          got_w;
  logic          ready_after;
  logic [1023:0] got_data;
  logic [1023:0] data_after;

  function automatic logic [1023:0] exp_line();
    logic [1023:0] l;
    for (int k = 0; k < 16; k++) l[64*k +: 64] = beat_data[k];
    return l;
  endfunction

  function automatic void model_accept(input logic w);
    if (w) begin
      if (wr_exp < 64'hFFFF_FFFF) wr_exp++;
    end else begin
      if (rd_exp < 64'hFFFF_FFFF) rd_exp++;
    end
  endfunction

  // Memory side reacts to the DUT; starts at a negedge, returns at the negedge after the fill cycle.
  task automatic do_miss(input logic [31:0] addr, input logic w, input int stall, input int gaps,
                         input bit stray, input bit pulses, input bit hold, input bit fixed);
    int stall_left, gaps_left, sent;
    bit req_done, seen;
    fill_cyc = -1; n_fill = 0; n_req = 0; req_addr_seen = '0;
    ready_after = 1'b0;
    for (int k = 0; k < 16; k++)
      beat_data[k] = fixed ? 64'h1111_0000_0000_0000 + 64'(k) : {$urandom(), $urandom()};
    stall_left = stall; gaps_left = gaps; sent = 0; req_done = 0; seen = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (seen && cyc == fill_cyc + 1) begin
        ready_after = miss_ready;
        data_after  = fill_data;
        break;
      end
      if (fill_valid) begin
        n_fill++;
        if (!seen) begin
          seen = 1; fill_cyc = cyc;
          got_data = fill_data; got_addr = fill_addr; got_w = fill_is_write;
        end
      end
      miss_valid = (cyc == 0) || hold || (pulses && (cyc == 3 || cyc == 10));
      if (cyc == 0) begin
        miss_addr = addr; miss_is_write = w;
      end else if (!hold) begin
        miss_addr = $urandom(); miss_is_write = 1'($urandom_range(0, 1));
      end
      if (mem_req_valid) begin
        req_addr_seen = mem_req_addr;
        if (stall_left > 0) begin
          mem_req_ready = 1'b0; stall_left--;
        end else begin
          mem_req_ready = 1'b1; n_req++;
        end
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
      mem_resp_valid = 1'b0;
      mem_resp_data  = {$urandom(), $urandom()};
      if (req_done && sent < 16) begin
        if (gaps_left > 0 && (sent == 15 || $urandom_range(0, 3) == 0)) begin
          gaps_left--;
        end else begin
          mem_resp_valid = 1'b1; mem_resp_data = beat_data[sent]; sent++;
        end
      end else if (stray) begin
        mem_resp_valid = 1'($urandom_range(0, 1));
      end
      if (mem_req_valid && mem_req_ready) req_done = 1;
      @(posedge clk); @(negedge clk);
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_valid = 1'b0; miss_is_write = 1'b0; miss_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    total++;
    if ({miss_ready, busy, mem_req_valid, fill_valid, fill_is_write} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags got=%b exp=10000",
                      {miss_ready, busy, mem_req_valid, fill_valid, fill_is_write});
    end
    total++;
    if (fill_data !== '0 || fill_addr !== '0 || mem_req_addr !== '0 ||
        rd_miss_count !== '0 || wr_miss_count !== '0) begin
      bad++; $display("FAIL reset_buses fa=%h ra=%h rd=%h wr=%h", fill_addr, mem_req_addr,
                      rd_miss_count, wr_miss_count);
    end
  endtask

  task automatic test_read_miss();
    do_miss(32'h0000_1234, 1'b0, 0, 0, 0, 0, 0, 1);
    model_accept(1'b0);
    total++;
    if (req_addr_seen !== 32'h0000_1200) begin
      bad++; $display("FAIL rd_req_addr got=%h exp=00001200", req_addr_seen);
    end
    total++;
    if (fill_cyc != 18) begin bad++; $display("FAIL rd_latency got=%0d exp=18", fill_cyc); end
    total++;
    if (got_addr !== 32'h0000_1200 || got_w !== 1'b0) begin
      bad++; $display("FAIL rd_fill_addr_type got=%h/%b exp=00001200/0", got_addr, got_w);
    end
    total++;
    if (got_data !== exp_line()) begin
      bad++; $display("FAIL rd_fill_data got=%h exp=%h", got_data[127:0], exp_line() >> 0);
    end
    total++;
    if (64'(rd_miss_count) != rd_exp || 64'(wr_miss_count) != wr_exp) begin
      bad++; $display("FAIL rd_counts got=%0d/%0d exp=%0d/%0d", rd_miss_count, wr_miss_count, rd_exp, wr_exp);
    end
    total++;
    if (ready_after !== 1'b1 || n_fill != 1) begin
      bad++; $display("FAIL rd_ready_after got=%b fills=%0d exp=1 fills=1", ready_after, n_fill);
    end
  endtask

  task automatic test_write_miss_stalls();
    do_miss(32'hFFFF_FFFC, 1'b1, 5, 3, 0, 0, 0, 0);
    model_accept(1'b1);
    total++;
    if (req_addr_seen !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL wr_req_addr got=%h exp=ffffff80", req_addr_seen);
    end
    total++;
    if (fill_cyc != 26) begin bad++; $display("FAIL wr_latency got=%0d exp=26", fill_cyc); end
    total++;
    if (got_w !== 1'b1 || got_data !== exp_line()) begin
      bad++; $display("FAIL wr_fill got_w=%b data_lo=%h exp_lo=%h", got_w, got_data[127:0], exp_line() >> 0);
    end
    total++;
    if (64'(wr_miss_count) != wr_exp || 64'(rd_miss_count) != rd_exp) begin
      bad++; $display("FAIL wr_counts got=%0d/%0d exp=%0d/%0d", rd_miss_count, wr_miss_count, rd_exp, wr_exp);
    end
  endtask

  task automatic test_reset_mid_burst();
    miss_valid = 1'b1; miss_is_write = 1'b1; miss_addr = 32'h0000_5040; mem_req_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc > 0) miss_valid = 1'b0;
      mem_resp_valid = (cyc >= 2);
      mem_resp_data  = {$urandom(), $urandom()};
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1; mem_resp_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; rd_exp = 0; wr_exp = 0;
    total++;
    if ({miss_ready, busy, mem_req_valid, fill_valid, fill_is_write} !== 5'b10000 ||
        fill_data !== '0 || fill_addr !== '0 || rd_miss_count !== '0 || wr_miss_count !== '0) begin
      bad++; $display("FAIL midreset_state flags=%b fa=%h wr=%0d",
                      {miss_ready, busy, mem_req_valid, fill_valid, fill_is_write}, fill_addr, wr_miss_count);
    end
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1; mem_resp_data = {$urandom(), $urandom()};
      @(posedge clk); @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || fill_data !== '0) begin
      bad++; $display("FAIL midreset_stray busy=%b data_lo=%h exp=0/0", busy, fill_data[127:0]);
    end
    do_miss(32'h0000_0080, 1'b0, 0, 0, 0, 0, 0, 0);
    model_accept(1'b0);
    total++;
    if (fill_cyc != 18 || got_addr !== 32'h0000_0080 || got_data !== exp_line()) begin
      bad++; $display("FAIL midreset_newline cyc=%0d addr=%h data_lo=%h exp_lo=%h", fill_cyc, got_addr,
                      got_data[127:0], exp_line() >> 0);
    end
    total++;
    if (64'(rd_miss_count) != rd_exp || 64'(wr_miss_count) != wr_exp) begin
      bad++; $display("FAIL midreset_counts got=%0d/%0d exp=%0d/%0d", rd_miss_count, wr_miss_count, rd_exp, wr_exp);
    end
  endtask

  task automatic test_busy_misses();
    logic w;
    w = 1'($urandom_range(0, 1));
    do_miss($urandom(), w, 0, 0, 0, 1, 0, 0);
    model_accept(w);
    total++;
    if (n_req != 1 || n_fill != 1) begin
      bad++; $display("FAIL busy_single got req=%0d fill=%0d exp=1/1", n_req, n_fill);
    end
    total++;
    if (64'(rd_miss_count) != rd_exp || 64'(wr_miss_count) != wr_exp) begin
      bad++; $display("FAIL busy_counts got=%0d/%0d exp=%0d/%0d", rd_miss_count, wr_miss_count, rd_exp, wr_exp);
    end
  endtask

  task automatic test_stray_beats();
    do_miss($urandom(), 1'b0, 3, 2, 1, 0, 0, 0);
    model_accept(1'b0);
    total++;
    if (fill_cyc != 23 || got_data !== exp_line()) begin
      bad++; $display("FAIL stray_line cyc=%0d exp=23 data_lo=%h exp_lo=%h", fill_cyc, got_data[127:0], exp_line() >> 0);
    end
    total++;
    if (data_after !== got_data) begin
      bad++; $display("FAIL stray_hold got_lo=%h exp_lo=%h", data_after[127:0], got_data[127:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    a = $urandom();
    do_miss(a, 1'b1, 0, 0, 0, 0, 1, 0);
    model_accept(1'b1);
    total++;
    if (fill_cyc != 18 || ready_after !== 1'b1 || n_fill != 1) begin
      bad++; $display("FAIL b2b_first cyc=%0d ready=%b fills=%0d exp=18/1/1", fill_cyc, ready_after, n_fill);
    end
    do_miss($urandom(), 1'b0, 1, 1, 1, 0, 0, 0);
    model_accept(1'b0);
    total++;
    if (fill_cyc != 20 || got_data !== exp_line() || n_req != 1) begin
      bad++; $display("FAIL b2b_second cyc=%0d exp=20 req=%0d data_lo=%h", fill_cyc, n_req, got_data[127:0]);
    end
    total++;
    if (64'(rd_miss_count) != rd_exp || 64'(wr_miss_count) != wr_exp) begin
      bad++; $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", rd_miss_count, wr_miss_count, rd_exp, wr_exp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic w;
      int st, gp;
      a = $urandom(); w = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 4); gp = $urandom_range(0, 5);
      do_miss(a, w, st, gp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      model_accept(w);
      total++;
      if (fill_cyc != 18 + st + gp || got_addr !== (a & 32'hFFFF_FF80) || got_w !== w ||
          got_data !== exp_line() || n_req != 1 || n_fill != 1) begin
        bad++; $display("FAIL rand%0d cyc=%0d exp=%0d addr=%h exp=%h w=%b exp=%b req=%0d fill=%0d", i,
                        fill_cyc, 18 + st + gp, got_addr, a & 32'hFFFF_FF80, got_w, w, n_req, n_fill);
      end
      total++;
      if (64'(rd_miss_count) != rd_exp || 64'(wr_miss_count) != wr_exp) begin
        bad++; $display("FAIL rand%0d_counts got=%0d/%0d exp=%0d/%0d", i, rd_miss_count, wr_miss_count, rd_exp, wr_exp);
      end
    end
  endtask

  task automatic test_saturation();
    miss_valid = 1'b0;
    force dut.rd_miss_count = 32'hFFFF_FFFE;
    @(posedge clk); @(negedge clk);
    release dut.rd_miss_count;
    rd_exp = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      do_miss($urandom(), 1'b0, 0, 0, 0, 0, 0, 0);
      model_accept(1'b0);
      total++;
      if (64'(rd_miss_count) != rd_exp) begin
        bad++; $display("FAIL sat%0d got=%h exp=%h", i, rd_miss_count, rd_exp[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_miss_stalls();
    test_reset_mid_burst();
    test_busy_misses();
    test_stray_beats();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_refill_unit.md
# dcache_refill_unit

Miss-service stage directly downstream of the L1 data-cache controller. It accepts one read- or write-miss repair request at a time, fetches the 128-byte block containing the missed address from main memory as a single burst of 16 × 64-bit beats, and assembles the beats into a 1024-bit line. It returns that line to the controller with a one-cycle fill strobe, which the controller treats as repair-resolved. It also keeps saturating miss counters for performance monitoring.

## Interface
- BLOCK_BITS, 1024, cache line width (128 B)
- BEAT_BITS, 64, memory data beat width; BEATS = BLOCK_BITS/BEAT_BITS = 16
- ADDR_W, 32, byte address width
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- miss_valid  in  1  repair request from cache controller (read or write miss)
- miss_is_write  in  1  1 = write-miss repair, 0 = read-miss repair
- miss_addr  in  ADDR_W  missed byte address
- miss_ready  out  1  high only in IDLE; request accepted when miss_valid & miss_ready
- mem_req_valid  out  1  burst read request to memory
- mem_req_addr  out  ADDR_W  block-aligned burst address
- mem_req_ready  in  1  memory accepts request when high with mem_req_valid
- mem_resp_valid  in  1  one data beat valid this cycle
- mem_resp_data  in  BEAT_BITS  beat data, in ascending address order
- fill_valid  out  1  one-cycle strobe: fill_data/fill_addr valid (drives repair_resolved)
- fill_addr  out  ADDR_W  block-aligned address of the filled line
- fill_data  out  BLOCK_BITS  assembled line
- fill_is_write  out  1  miss_is_write of the serviced request
- busy  out  1  high in any state other than IDLE
- rd_miss_count, wr_miss_count  out  32 each  accepted misses by type, saturating at 0xFFFF_FFFF

## Operation
- States: IDLE, REQ, RECV, FILL.
- IDLE: miss_ready=1. On miss_valid, capture addr_q = miss_addr & ~32'h7F and is_write_q = miss_is_write, increment the matching counter (saturating), clear beat_cnt, and go to REQ. Otherwise stay in IDLE.
- REQ: mem_req_valid=1 and mem_req_addr=addr_q. Wait in REQ for mem_req_ready, then go to RECV. The request is held stable while waiting.
- RECV: on each mem_resp_valid, write line_q[BEAT_BITS*beat_cnt +: BEAT_BITS] = mem_resp_data and increment beat_cnt (4-bit). On the beat with beat_cnt==15, go to FILL. Gaps between beats (mem_resp_valid=0) are allowed, and the unit holds state during them.
- FILL: fill_valid=1 for exactly one cycle, then go to IDLE.
- fill_data=line_q, fill_addr=addr_q and fill_is_write=is_write_q at all times. These values stay stable from FILL until the next miss is accepted.
- mem_resp_valid outside RECV is ignored; line_q is unchanged.
- miss_valid while busy is ignored and not counted. The controller holds its request until fill_valid.
- Counters never wrap. At 0xFFFF_FFFF a further increment leaves the value unchanged.

## Timing
- Reset: state=IDLE, beat_cnt=0, line_q=0, addr_q=0, is_write_q=0, counters=0. Outputs after reset: miss_ready=1, all other 1-bit outputs=0, all buses=0.
- Reset mid-burst: go to IDLE immediately on the next edge and discard the partial line. Beats still arriving from memory afterwards are ignored.
- Minimum latency, with mem_req_ready=1 and a beat every cycle:
  - miss accepted at cycle 0
  - REQ at cycle 1, with the handshake in that cycle
  - RECV at cycles 2–17
  - fill_valid at cycle 18
  - miss_ready again at cycle 19
- Each cycle of mem_req_ready=0 in REQ, and each idle cycle in RECV, adds one cycle to the latency.
- Back-to-back misses: a new miss can be accepted the cycle after FILL, not during FILL.
- Only one mem request is issued per miss. mem_req_valid is never high outside REQ.

## Test plan
- Single read miss at addr 0x0000_1234, mem_req_ready=1, beats k=0..15 with data 64'h1111_0000_0000_0000+k every cycle:
  - mem_req_addr=0x0000_1200
  - fill_valid at cycle 18, fill_addr=0x0000_1200
  - fill_data beat k equals the beat-k data
  - fill_is_write=0, rd_miss_count=1
- Write miss at 0xFFFF_FFFC, mem_req_ready low for 5 cycles, beats with 3 idle gaps:
  - mem_req_addr=0xFFFF_FF80
  - fill_valid at cycle 26, fill_is_write=1, wr_miss_count=1
- Reset asserted after beat 7, then a new miss at 0x0000_0080:
  - state returns to IDLE and outputs take their reset values
  - stray beats arriving in IDLE are ignored
  - new fill_data contains only beats from the new burst
- miss_valid pulsed at cycles 3 and 10 during an active refill:
  - not counted and no second mem request
  - exactly one fill_valid strobe
- Stray mem_resp_valid in IDLE and REQ leaves line_q unchanged; the subsequent line is correct.
- Counter preloaded via force to 0xFFFF_FFFE, then 3 read misses → rd_miss_count=0xFFFF_FFFF, no wrap.
